// File: rtl/output_dma_framer_pkg.sv
// Shared constants and types for the output DMA framer: system widths and FSM encoding.
package output_dma_framer_pkg;

    localparam int OUTPUT_DMA_WIDTH = 64;
    localparam int BEAT_COUNT_WIDTH = 20;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/output_dma_framer_skid.sv
// Two-entry AXI-Stream register slice (main output register plus skid register).
// The upstream ready is generated by the parent from skid_valid_nxt so it can be registered.
module axis_skid_buffer #(
    parameter int WIDTH = 65
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             push,
    input  logic [WIDTH-1:0] s_payload,
    output logic             skid_valid_nxt,
    output logic [WIDTH-1:0] m_payload,
    output logic             m_valid,
    input  logic             m_ready
);

    logic             main_valid_q, main_valid_d;
    logic [WIDTH-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [WIDTH-1:0] skid_data_q,  skid_data_d;
    logic             main_free;

    // The parent only pushes while the skid register was empty last cycle,
    // so a push never coincides with an occupied skid register.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        main_free    = !main_valid_q || m_ready;

        if (skid_valid_q) begin
            if (main_free) begin
                main_valid_d = 1'b1;
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_free) begin
            main_valid_d = push;
            if (push) begin
                main_data_d = s_payload;
            end
        end else if (push) begin
            skid_valid_d = 1'b1;
            skid_data_d  = s_payload;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            // NOTE: payload registers are reset too because the output data must read 0 during reset.
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign skid_valid_nxt = skid_valid_d;
    assign m_payload      = main_data_q;
    assign m_valid        = main_valid_q;

endmodule

// File: rtl/output_dma_framer.sv
// Frames one layer's output stream into a single DMA transfer of a programmed beat count,
// generating M_AXIS_tlast and flagging upstream tlast disagreements.
module output_dma_framer #(
    parameter int DATA_WIDTH       = output_dma_framer_pkg::OUTPUT_DMA_WIDTH,
    parameter int BEAT_COUNT_WIDTH = output_dma_framer_pkg::BEAT_COUNT_WIDTH
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    input  logic                        start,
    input  logic [BEAT_COUNT_WIDTH-1:0] beats_per_frame,
    input  logic [DATA_WIDTH-1:0]       S_AXIS_tdata,
    input  logic                        S_AXIS_tvalid,
    output logic                        S_AXIS_tready,
    input  logic                        S_AXIS_tlast,
    output logic [DATA_WIDTH-1:0]       M_AXIS_tdata,
    output logic                        M_AXIS_tvalid,
    input  logic                        M_AXIS_tready,
    output logic                        M_AXIS_tlast,
    output logic [DATA_WIDTH/8-1:0]     M_AXIS_tkeep,
    output logic                        busy,
    output logic                        done,
    output logic                        err_early_last,
    output logic                        err_late_last
);

    import output_dma_framer_pkg::*;

    state_e                      state_q, state_d;
    logic [BEAT_COUNT_WIDTH-1:0] n_q, n_d;
    logic [BEAT_COUNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [BEAT_COUNT_WIDTH-1:0] last_idx;
    logic                        err_early_q, err_early_d;
    logic                        err_late_q, err_late_d;
    logic                        done_q, done_d;
    logic                        tready_q, tready_d;

    logic                        start_ok;
    logic                        up_hs;
    logic                        is_final;
    logic                        last_popped;
    logic                        skid_valid_nxt;
    logic [DATA_WIDTH:0]         m_payload;

    // A start in the done cycle is dropped: the frame is only truly over one cycle later.
    assign start_ok    = start && (state_q == IDLE) && !done_q;
    assign up_hs       = S_AXIS_tvalid && tready_q;
    assign last_idx    = n_q - 1'b1;
    assign is_final    = (beat_cnt_q == last_idx);
    assign last_popped = M_AXIS_tvalid && M_AXIS_tready && M_AXIS_tlast;

    axis_skid_buffer #(
        .WIDTH (DATA_WIDTH + 1)
    ) u_skid (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .push           (up_hs),
        .s_payload      ({is_final, S_AXIS_tdata}),
        .skid_valid_nxt (skid_valid_nxt),
        .m_payload      (m_payload),
        .m_valid        (M_AXIS_tvalid),
        .m_ready        (M_AXIS_tready)
    );

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_ok && (beats_per_frame != '0)) state_d = RUN;
            RUN:     if (up_hs && is_final)                   state_d = DRAIN;
            DRAIN:   if (last_popped)                         state_d = IDLE;
            default:                                          state_d = IDLE;
        endcase
    end

    always_comb begin
        n_d         = n_q;
        beat_cnt_d  = beat_cnt_q;
        err_early_d = err_early_q;
        err_late_d  = err_late_q;
        done_d      = 1'b0;

        if (start_ok) begin
            n_d         = beats_per_frame;
            beat_cnt_d  = '0;
            err_early_d = 1'b0;
            err_late_d  = 1'b0;
            done_d      = (beats_per_frame == '0);
        end

        if (up_hs) begin
            if (is_final) begin
                if (!S_AXIS_tlast) err_late_d = 1'b1;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
                if (S_AXIS_tlast) err_early_d = 1'b1;
            end
        end

        if ((state_q == DRAIN) && last_popped) begin
            done_d = 1'b1;
        end

        // Ready is decided one cycle ahead from next-cycle state, keeping M_AXIS_tready off the upstream path.
        tready_d = (state_d == RUN) && !skid_valid_nxt;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            n_q         <= '0;
            beat_cnt_q  <= '0;
            err_early_q <= 1'b0;
            err_late_q  <= 1'b0;
            done_q      <= 1'b0;
            tready_q    <= 1'b0;
        end else begin
            n_q         <= n_d;
            beat_cnt_q  <= beat_cnt_d;
            err_early_q <= err_early_d;
            err_late_q  <= err_late_d;
            done_q      <= done_d;
            tready_q    <= tready_d;
        end
    end

    always_comb begin
        busy           = (state_q != IDLE);
        done           = done_q;
        S_AXIS_tready  = tready_q;
        err_early_last = err_early_q;
        err_late_last  = err_late_q;
        M_AXIS_tdata   = m_payload[DATA_WIDTH-1:0];
        M_AXIS_tlast   = m_payload[DATA_WIDTH];
        M_AXIS_tkeep   = '1;
    end

endmodule

// File: tb/tb_output_dma_framer.sv
// Self-checking bench for output_dma_framer: directed frames with random payloads,
// checked against a queue-based reference of what each frame must emit.
module tb_output_dma_framer;

    localparam int DW = 64;
    localparam int BW = 20;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic          start;
    logic [BW-1:0] beats_per_frame;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [DW/8-1:0] m_tkeep;
    logic          busy;
    logic          done;
    logic          err_early_last;
    logic          err_late_last;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] src_data[$];
    bit            src_last[$];

    output_dma_framer #(
        .DATA_WIDTH       (DW),
        .BEAT_COUNT_WIDTH (BW)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .start           (start),
        .beats_per_frame (beats_per_frame),
        .S_AXIS_tdata    (s_tdata),
        .S_AXIS_tvalid   (s_tvalid),
        .S_AXIS_tready   (s_tready),
        .S_AXIS_tlast    (s_tlast),
        .M_AXIS_tdata    (m_tdata),
        .M_AXIS_tvalid   (m_tvalid),
        .M_AXIS_tready   (m_tready),
        .M_AXIS_tlast    (m_tlast),
        .M_AXIS_tkeep    (m_tkeep),
        .busy            (busy),
        .done            (done),
        .err_early_last  (err_early_last),
        .err_late_last   (err_late_last)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic gen_src(input int cnt, input int tl_at);
        src_data.delete();
        src_last.delete();
        for (int i = 0; i < cnt; i++) begin
            src_data.push_back({$urandom(), $urandom()});
            src_last.push_back(i == tl_at);
        end
    endtask

    // Downstream ready patterns: 0 always, 1 the 1,0,0,1 cycle, 2 one beat then stall, 3 random.
    function automatic logic ready_for(input int mode, input int cyc, input int outc);
        case (mode)
            0:       return 1'b1;
            1:       return ((cyc % 4) == 0) || ((cyc % 4) == 3);
            2:       return outc < 1;
            default: return $urandom_range(0, 1) == 1;
        endcase
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_m_tvalid"}, m_tvalid, 1'b0);
        check({tag, "_m_tdata"}, m_tdata, 64'h0);
        check({tag, "_m_tlast"}, m_tlast, 1'b0);
        check({tag, "_s_tready"}, s_tready, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_err_early"}, err_early_last, 1'b0);
        check({tag, "_err_late"}, err_late_last, 1'b0);
        check({tag, "_tkeep"}, m_tkeep, 8'hFF);
    endtask

    // Starts a frame of n beats from the current source queue and runs it cycle by cycle,
    // entered and left at a falling edge.
    task automatic run_frame(input int n, input int mode, input int restart_cyc,
                             input int stop_after, input bit chk_lat);
        int acc = 0;
        int outc = 0;
        int dones = 0;
        int cyc = 0;
        int done_cyc = -1;
        int first_in = -1;
        int first_out = -1;
        int last_out = -1;
        bit stall = 1'b0;
        logic [DW-1:0] stall_data = '0;
        logic stall_last = 1'b0;
        bit up;
        bit dn;
        bit exp_early;
        bit exp_late;

        start = 1'b1;
        beats_per_frame = BW'(n);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        @(posedge aclk);
        @(negedge aclk);
        start = 1'b0;
        check("busy_after_start", busy, 1'b1);

        while (cyc < 500) begin
            s_tvalid = (acc < src_data.size());
            if (s_tvalid) begin
                s_tdata = src_data[acc];
                s_tlast = src_last[acc];
            end else begin
                s_tdata = '0;
                s_tlast = 1'b0;
            end
            m_tready = ready_for(mode, cyc, outc);
            start = (cyc == restart_cyc);
            beats_per_frame = start ? BW'(3) : BW'(n);

            up = s_tvalid && s_tready;
            dn = m_tvalid && m_tready;
            if (stall) begin
                check("stall_valid", m_tvalid, 1'b1);
                check("stall_data", m_tdata, stall_data);
                check("stall_last", m_tlast, stall_last);
            end
            if (dn) begin
                if (outc < src_data.size()) begin
                    check("out_data", m_tdata, src_data[outc]);
                    check("out_last", m_tlast, outc == n - 1);
                end
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                outc++;
            end
            stall = m_tvalid && !m_tready;
            stall_data = m_tdata;
            stall_last = m_tlast;
            if (up) begin
                if (first_in < 0) first_in = cyc;
                acc++;
            end

            @(posedge aclk);
            @(negedge aclk);
            start = 1'b0;
            cyc++;
            if (done) begin
                dones++;
                done_cyc = cyc;
                check("busy_low_at_done", busy, 1'b0);
            end
            if (stop_after > 0 && acc >= stop_after) break;
            if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
        end

        if (stop_after > 0) begin
            check("partial_accept", acc, stop_after);
            return;
        end

        exp_early = 1'b0;
        for (int i = 0; i < n - 1; i++) begin
            if (src_last[i]) exp_early = 1'b1;
        end
        exp_late = !src_last[n-1];

        check("done_once", dones, 1);
        check("accepted", acc, n);
        check("emitted", outc, n);
        check("err_early_last", err_early_last, exp_early);
        check("err_late_last", err_late_last, exp_late);
        check("busy_after_frame", busy, 1'b0);
        if (chk_lat) begin
            check("latency", first_out - first_in, 1);
            check("back_to_back", last_out - first_out, n - 1);
        end
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        s_tdata = '0;
        m_tready = 1'b1;
    endtask

    initial begin
        int n;

        aresetn = 1'b0;
        start = 1'b0;
        beats_per_frame = '0;
        s_tdata = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b1;
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check_all_zero("reset");
        aresetn = 1'b1;
        @(negedge aclk);
        check_all_zero("post_reset");

        // N=4, full throughput, tlast on beat 3.
        gen_src(4, 3);
        run_frame(4, 0, -1, 0, 1'b1);

        // N=8 under 1,0,0,1 backpressure.
        gen_src(8, 7);
        run_frame(8, 1, -1, 0, 1'b0);

        // N=5 with early upstream tlast on beat 2 and a sixth beat offered.
        gen_src(6, 2);
        run_frame(5, 0, -1, 0, 1'b0);

        // Zero-length frame, then a start in the done cycle, then N=2.
        gen_src(2, 1);
        s_tvalid = 1'b1;
        s_tdata = src_data[0];
        start = 1'b1;
        beats_per_frame = '0;
        @(posedge aclk);
        @(negedge aclk);
        start = 1'b0;
        check("zero_done", done, 1'b1);
        check("zero_busy", busy, 1'b0);
        check("zero_no_accept", s_tready, 1'b0);
        check("zero_err_early_cleared", err_early_last, 1'b0);
        check("zero_err_late_cleared", err_late_last, 1'b0);
        start = 1'b1;
        beats_per_frame = BW'(2);
        @(posedge aclk);
        @(negedge aclk);
        start = 1'b0;
        check("start_in_done_ignored", busy, 1'b0);
        check("zero_done_single", done, 1'b0);
        s_tvalid = 1'b0;
        run_frame(2, 0, -1, 0, 1'b0);

        // Reset after 3 of 10 beats with stalled skid data.
        gen_src(10, 9);
        run_frame(10, 2, -1, 3, 1'b0);
        check("stalled_before_reset", m_tvalid, 1'b1);
        s_tvalid = 1'b0;
        aresetn = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        check_all_zero("after_mid_reset");
        gen_src(3, 2);
        run_frame(3, 0, -1, 0, 1'b1);

        // Second start during RUN is ignored.
        gen_src(6, 5);
        run_frame(6, 0, 2, 0, 1'b0);

        // Random frames with random tlast position and random backpressure.
        for (int k = 0; k < 4; k++) begin
            n = $urandom_range(1, 12);
            gen_src(n + 1, $urandom_range(0, n));
            run_frame(n, 3, -1, 0, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/output_dma_framer.md
Name: output_dma_framer

Overview:
- Stage directly downstream of the full pipeline's LeakyReLU output stream, between it and the output DMA S2MM port.
- Frames each layer's output as one DMA transfer of a programmed beat count, and asserts M_AXIS_tlast on exactly the last beat.
- Checks the upstream tlast against the programmed count and raises sticky error flags on a mismatch.
- Uses a 2-entry skid buffer to give full throughput and a registered output.

Parameters:
- DATA_WIDTH, 64: output DMA data width in bits. Equals OUTPUT_DMA_WIDTH.
- BEAT_COUNT_WIDTH, 20: width of the beat counter and of beats_per_frame.

Ports:
- aclk  in  1: clock.
- aresetn  in  1: asynchronous active-low reset.
- start  in  1: one-cycle pulse that arms a frame. Ignored while busy.
- beats_per_frame  in  BEAT_COUNT_WIDTH: beats in the frame. Sampled on an accepted start.
- S_AXIS_tdata  in  DATA_WIDTH: upstream data.
- S_AXIS_tvalid  in  1: upstream valid.
- S_AXIS_tready  out  1: ready to upstream.
- S_AXIS_tlast  in  1: upstream last. Used for checking only.
- M_AXIS_tdata  out  DATA_WIDTH: data to DMA.
- M_AXIS_tvalid  out  1: valid to DMA.
- M_AXIS_tready  in  1: DMA ready.
- M_AXIS_tlast  out  1: last beat of the frame.
- M_AXIS_tkeep  out  DATA_WIDTH/8: byte enables, all ones.
- busy  out  1: high from an accepted start until done.
- done  out  1: one-cycle pulse when the final beat has been accepted downstream.
- err_early_last  out  1: sticky. Upstream tlast arrived before the final beat.
- err_late_last  out  1: sticky. Final beat arrived without upstream tlast.

Behaviour:
- Reset (asynchronous, active-low) clears all state at any time, including mid-frame.
  - All outputs go to 0; M_AXIS_tkeep is the only exception and is constant all ones.
  - Skid contents are discarded and the FSM returns to IDLE.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - S_AXIS_tready = 0.
  - On start with beats_per_frame != 0: latch the count N, clear beat_cnt and both error flags, busy=1, go to RUN.
  - On start with beats_per_frame == 0: clear both error flags, pulse done the next cycle, stay in IDLE. busy stays 0.
- RUN:
  - An upstream handshake occurs when S_AXIS_tvalid && S_AXIS_tready. On each one, beat_cnt increments and the beat is written to the skid buffer.
  - M_AXIS_tlast is attached to the beat where beat_cnt == N-1.
  - Upstream tlast on a beat with beat_cnt < N-1: set err_early_last. The beat is forwarded with M_AXIS_tlast=0 and counting continues.
  - Final beat (beat_cnt == N-1) without upstream tlast: set err_late_last.
  - After the final beat is accepted, S_AXIS_tready drops in the next cycle and the FSM goes to DRAIN.
  - No beat beyond N is ever accepted.
- DRAIN:
  - S_AXIS_tready = 0.
  - When the tlast beat completes a downstream handshake (M_AXIS_tvalid && M_AXIS_tready), pulse done for one cycle the next cycle, busy=0, go to IDLE.
- Skid buffer: 2 entries, with a main output register and a skid register.
  - S_AXIS_tready in RUN = (skid register empty) && (not past the final beat). S_AXIS_tready is registered, with no combinational path from M_AXIS_tready.
  - Latency from upstream handshake to M_AXIS_tvalid is 1 cycle.
  - Sustains 1 beat/cycle when M_AXIS_tready is held high.
  - Under backpressure, M_AXIS_tdata, M_AXIS_tvalid and M_AXIS_tlast stay stable until a downstream handshake (AXI-Stream rule).
  - Simultaneous push and pop in one cycle is supported.
  - When M_AXIS_tready deasserts, one in-flight beat lands in the skid register.
- Simultaneous events:
  - A start pulse while busy is ignored, including in the cycle done pulses.
  - Start in the cycle after done is accepted.
- Counter wrap: not possible. beat_cnt only counts to N-1.
- Error flags hold until the next accepted start or reset.

Decomposition:
- Shared package/header, next to the system parameters:
  - OUTPUT_DMA_WIDTH, reused for DATA_WIDTH.
  - BEAT_COUNT_WIDTH.
  - FSM state encodings IDLE=2'd0, RUN=2'd1, DRAIN=2'd2.
- One sub-module: axis_skid_buffer. It holds the 2-entry register slice with payload {tlast, tdata}, width parameterised.
- The framer holds the FSM, beat counter and tlast checker.

Test Plan:
- N=4, upstream sends 4 beats with tlast on beat 3, M_AXIS_tready held high:
  - Expect 4 output beats in 4 consecutive cycles, 1-cycle latency.
  - M_AXIS_tlast only on beat 3; done pulses once; both error flags 0.
- N=8, M_AXIS_tready toggling 1,0,0,1 repeatedly:
  - Data order and values are preserved with no drops or duplicates.
  - Output stays stable while stalled; exactly 8 beats are emitted.
- N=5, upstream tlast on beat 2:
  - err_early_last=1; M_AXIS_tlast only on beat 4.
  - err_late_last=1, since beat 4 carries no upstream tlast.
  - The 6th upstream beat is not accepted.
- Start with beats_per_frame=0:
  - done pulses; no beats are accepted; busy stays 0.
  - A following start with N=2 works normally.
- Reset pulse mid-frame (after 3 of 10 beats, with stalled skid data):
  - All outputs go to 0 immediately and the FSM is in IDLE.
  - A following frame with N=3 completes cleanly.
- Second start during RUN (N=6):
  - Ignored; the frame still ends after 6 beats; done pulses once.
